gpio_arbiter: RTL
=================

Name: gpio_arbiter

Overview:
Two-requester arbiter and sequencer in front of the board GPIO register block.
- Master 0 is the core load/store port; master 1 is the secondary port (debug/loader).
- Accepts one request at a time, with round-robin priority.
- Decodes the GPIO address window and drives the GPIO write strobe, address and data.
- Returns the GPIO read word, or an error for out-of-window addresses, to the owning master.

Parameters:
ADDR_W, 11, address width of master and GPIO address buses
DATA_W, 32, data width
GPIO_BASE, 11'h7F0, first address of the GPIO window
GPIO_SPAN, 16, window size in addresses; valid when GPIO_BASE <= addr < GPIO_BASE+GPIO_SPAN

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
m0_req, m1_req  in  1  request; held with addr/we/wdata stable until gnt
m0_we, m1_we  in  1  1=write, 0=read
m0_addr, m1_addr  in  ADDR_W  request address
m0_wdata, m1_wdata  in  DATA_W  write data
m0_lock, m1_lock  in  1  keep ownership for next transaction (used only with GPIO_ARB_LOCK_EN)
m0_gnt, m1_gnt  out  1  one-cycle accept pulse
m0_rvalid, m1_rvalid  out  1  one-cycle completion pulse (reads and writes)
m0_err, m1_err  out  1  valid with rvalid; address outside window
rdata  out  DATA_W  shared read data, qualified by mX_rvalid
gpio_we  out  1  write strobe to GPIO block
gpio_addr  out  ADDR_W  latched address to GPIO block
gpio_wdata  out  DATA_W  latched write data to GPIO block
gpio_rdata  in  DATA_W  registered read word from GPIO block
busy  out  1  high in ACCESS or RESP

Behaviour:
- Reset, asynchronous, RST_N=0:
  - state=IDLE, rr_ptr=0 (master 0 preferred).
  - All outputs 0; latched addr/wdata/we/owner cleared.
  - An in-flight transaction is dropped: no rvalid is ever issued for it.
- FSM: IDLE -> ACCESS -> RESP -> IDLE, one cycle per state. Throughput is one transaction per 3 cycles.
- IDLE:
  - If any req, pick the winner: single requester wins; if both, the master at rr_ptr wins.
  - Assert the winner's gnt this cycle, combinationally from req and state.
  - Latch owner, we, addr, wdata, and in_win = window decode of addr.
  - Go to ACCESS.
- ACCESS:
  - gpio_addr and gpio_wdata are driven from the latches.
  - gpio_we = latched_we & in_win; there is never a GPIO write for an out-of-window address.
  - Go to RESP.
- RESP:
  - owner's rvalid=1, err=~in_win.
  - rdata = gpio_rdata when read and in_win; otherwise 0.
  - rr_ptr <= ~owner. Go to IDLE.
- Read latency: gnt at cycle T, rvalid at T+2. gpio_rdata sampled at T+2 reflects the GPIO input captured on the T+1 edge, because gpio_we=0 during a read ACCESS.
- Write completion: rvalid at T+2; GPIO outputs update on the T+2 edge.
- Requests are ignored in ACCESS and RESP, with no gnt. The requester keeps req high and is served in a later IDLE.
- Window check uses unsigned compare at ADDR_W bits; GPIO_BASE+GPIO_SPAN must not exceed 2^ADDR_W (elaboration assertion).
- gnt, rvalid and err are never asserted to both masters in the same cycle.

Optional Feature:
GPIO_ARB_LOCK_EN
- Defined: if the owner's lock=1 at RESP, rr_ptr is not rotated and the owner keeps priority on the next IDLE even if the other master requests.
  - A lock held longer than 8 consecutive transactions is overridden: an internal 3-bit counter forces rotation.
- Undefined: lock inputs are ignored; strict round-robin.

Decomposition:
- Shared package gpio_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - owner type (1 bit)
  - GPIO_BASE/GPIO_SPAN defaults
  - register offsets: LEDR=0, LEDG=1, HEX=2, DIN=3
- One natural sub-module, gpio_rr_pick: 2-way round-robin winner select from req[1:0] and rr_ptr, with lock/counter logic when enabled.

Test Plan:
1. Reset mid-ACCESS: m0 write to 11'h7F0, RST_N low at T+1 -> no rvalid, gpio_we=0, busy=0, state IDLE after release.
2. m0 read 11'h7F3 with gpio_rdata=32'h0001_2345 -> m0_gnt at T, gpio_we=0 at T+1, m0_rvalid=1, m0_err=0, rdata=32'h0001_2345 at T+2.
3. m1 write 11'h7F0 data 32'h0003_FFFF -> gpio_we=1 exactly one cycle at T+1 with gpio_wdata=32'h0003_FFFF, m1_rvalid at T+2.
4. Both req held continuously -> grant order m0, m1, m0, m1, each gnt 3 cycles apart.
5. m0 write 11'h100 (out of window) -> gpio_we stays 0, m0_rvalid=1, m0_err=1, rdata=0.
6. GPIO_ARB_LOCK_EN, m0_lock=1, both req held -> 8 m0 grants, then a forced m1 grant.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO arbiter slice: FSM states, owner type,
// GPIO window defaults and GPIO register offsets.
package gpio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic owner_t;

  typedef enum logic [1:0] {
    REG_LEDR = 2'd0,
    REG_LEDG = 2'd1,
    REG_HEX  = 2'd2,
    REG_DIN  = 2'd3
  } gpio_reg_t;

  localparam int          GPIO_ADDR_W_DEF = 11;
  localparam int          GPIO_DATA_W_DEF = 32;
  localparam int unsigned GPIO_BASE_DEF   = 32'h7F0;
  localparam int unsigned GPIO_SPAN_DEF   = 16;
  localparam int          LOCK_MAX        = 8;

  // Unsigned window test done at 32 bits so base+span can never wrap.
  function automatic logic in_window(input int unsigned addr,
                                     input int unsigned base,
                                     input int unsigned span);
    return (addr >= base) && (addr < base + span);
  endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// Two-way round-robin winner select with the rotation pointer; with
// GPIO_ARB_LOCK_EN the owner may keep priority for up to 8 transactions.
module gpio_rr_pick
  import gpio_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic       update,
  input  owner_t     owner,
  output owner_t     winner
);

  owner_t rr_ptr;

  // NOTE: default assignment first so every path assigns winner; no latch.
  always_comb begin
    winner = rr_ptr;
    if (req == 2'b01)      winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
  end

`ifdef GPIO_ARB_LOCK_EN
  logic [2:0] lock_cnt;
  logic       keep;

  // Counter reaching LOCK_MAX-1 means this is the 8th locked transaction in a row.
  assign keep = lock[owner] && (lock_cnt != 3'(LOCK_MAX - 1));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr   <= 1'b0;
      lock_cnt <= 3'd0;
    end else if (update) begin
      if (keep) begin
        rr_ptr   <= owner;
        lock_cnt <= lock_cnt + 3'd1;
      end else begin
        rr_ptr   <= ~owner;
        lock_cnt <= 3'd0;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      rr_ptr <= 1'b0;
    else if (update) rr_ptr <= ~owner;
  end
`endif

endmodule

// File: rtl/gpio_arbiter.sv
// Two-master arbiter/sequencer in front of the GPIO register block.
// Optional ownership lock enabled by defining GPIO_ARB_LOCK_EN.
module gpio_arbiter
  import gpio_pkg::*;
#(
  parameter int                ADDR_W    = GPIO_ADDR_W_DEF,
  parameter int                DATA_W    = GPIO_DATA_W_DEF,
  parameter logic [ADDR_W-1:0] GPIO_BASE = ADDR_W'(GPIO_BASE_DEF),
  parameter int                GPIO_SPAN = GPIO_SPAN_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_lock,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              m0_err,
  output logic              m1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              gpio_we,
  output logic [ADDR_W-1:0] gpio_addr,
  output logic [DATA_W-1:0] gpio_wdata,
  input  logic [DATA_W-1:0] gpio_rdata,
  output logic              busy
);

  localparam int unsigned WIN_END = 32'(GPIO_BASE) + 32'(GPIO_SPAN);

  if (WIN_END > (32'd1 << ADDR_W)) begin : g_window_check
    $error("gpio_arbiter: GPIO window exceeds the address space");
  end

  state_t            state_q, state_d;
  owner_t            owner_q, winner;
  logic              we_q, in_win_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              any_req, accept;
  logic [ADDR_W-1:0] sel_addr;

  assign any_req  = m0_req | m1_req;
  assign accept   = (state_q == IDLE) && any_req;
  assign sel_addr = winner ? m1_addr : m0_addr;

  gpio_rr_pick u_rr_pick (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .req    ({m1_req, m0_req}),
    .lock   ({m1_lock, m0_lock}),
    .update (state_q == RESP),
    .owner  (owner_q),
    .winner (winner)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured at grant so the master may change its bus right after gnt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      in_win_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      owner_q  <= winner;
      we_q     <= winner ? m1_we : m0_we;
      in_win_q <= in_window(32'(sel_addr), 32'(GPIO_BASE), 32'(GPIO_SPAN));
      addr_q   <= sel_addr;
      wdata_q  <= winner ? m1_wdata : m0_wdata;
    end
  end

  assign gpio_addr  = addr_q;
  assign gpio_wdata = wdata_q;

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    rdata     = '0;
    gpio_we   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        m0_gnt = accept & ~winner;
        m1_gnt = accept &  winner;
      end
      ACCESS: gpio_we = we_q & in_win_q;
      RESP: begin
        m0_rvalid = ~owner_q;
        m1_rvalid =  owner_q;
        m0_err    = ~owner_q & ~in_win_q;
        m1_err    =  owner_q & ~in_win_q;
        if (!we_q && in_win_q) rdata = gpio_rdata;
      end
      default: ;
    endcase
  end

endmodule
